// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider scheduler: FSM state encoding,
// default geometry and the quotient value reported for a zero divisor.
package div_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREQ  = 2;

  // Wide all-ones source; users cast it down to their own WIDTH.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_rr_arbiter.sv
// Round-robin request arbiter for the shared divider.
// Ports:
//   req_valid  in   NREQ  pending requests
//   ptr        in   ID_W  id granted last; search starts just after it
//   enable     in   1     arbitration allowed (divider idle)
//   grant      out  NREQ  one-hot grant (combinational)
//   grant_id   out  ID_W  encoded grant (combinational)
module div_rr_arbiter
  import div_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // Walk indices ptr+1, ptr+2, ... (wrapping) and take the first valid one.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = ID_W'((32'(ptr) + k) % NREQ);
      if (enable && !w_found && req_valid[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_id     = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Shares one restoring shift-subtract unsigned divider (one quotient bit per
// cycle) between NREQ requesters; results return tagged with requester id.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          per-requester handshake (ready is one-hot, combinational)
//   req_dividend/req_divisor     requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready          response handshake
//   rsp_id/quotient/remainder    registered result, held until accepted
//   rsp_div0                     divisor was zero
//   busy                         an operation is in flight or being presented
module div_scheduler
  import div_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned NREQ  = DEF_NREQ,
  localparam int unsigned ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_div0,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t          r_state, w_state_nxt;
  logic [ID_W-1:0] r_ptr, r_id, w_grant_id;
  logic [NREQ-1:0] w_grant;
  logic [WIDTH-1:0] r_dvd, r_dsr, r_rem;
  logic [WIDTH-1:0] w_sel_dvd, w_sel_dsr, w_rem_nxt;
  logic [WIDTH:0]  w_trial;
  logic            w_qbit, w_accept;
  logic [CNT_W-1:0] r_cnt;

  div_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .enable    (r_state == S_IDLE),
    .grant     (w_grant),
    .grant_id  (w_grant_id)
  );

  assign req_ready = w_grant;
  assign w_accept  = |(w_grant & req_valid);
  assign w_sel_dvd = req_dividend[w_grant_id*WIDTH +: WIDTH];
  assign w_sel_dsr = req_divisor[w_grant_id*WIDTH +: WIDTH];
  assign busy      = (r_state != S_IDLE);

  // Partial remainder shifted up with the next dividend bit; kept WIDTH+1 wide
  // so the compare never overflows when the divisor is near full scale.
  assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
  assign w_qbit    = (w_trial >= {1'b0, r_dsr});
  assign w_rem_nxt = w_qbit ? WIDTH'(w_trial - {1'b0, r_dsr}) : WIDTH'(w_trial);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (w_sel_dsr == '0) ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath, rr pointer and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= ID_W'(NREQ - 1);
      r_id          <= '0;
      r_dvd         <= '0;
      r_dsr         <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_div0      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ptr <= w_grant_id;
            r_id  <= w_grant_id;
            r_dvd <= w_sel_dvd;
            r_dsr <= w_sel_dsr;
            r_rem <= '0;
            r_cnt <= CNT_W'(WIDTH - 1);
            // Zero divisor bypasses the iteration entirely.
            if (w_sel_dsr == '0) begin
              rsp_valid     <= 1'b1;
              rsp_id        <= w_grant_id;
              rsp_quotient  <= WIDTH'(DIV0_QUOTIENT);
              rsp_remainder <= w_sel_dvd;
              rsp_div0      <= 1'b1;
            end
          end
        end
        S_CALC: begin
          // Quotient bits fill r_dvd from the bottom as dividend bits leave the top.
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            rsp_valid     <= 1'b1;
            rsp_id        <= r_id;
            rsp_quotient  <= {r_dvd[WIDTH-2:0], w_qbit};
            rsp_remainder <= w_rem_nxt;
            rsp_div0      <= 1'b0;
          end
        end
        S_DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Scoreboard bench for div_scheduler: drivers push requests per requester,
// a negedge monitor models arbitration/occupancy and checks responses.
module tb_div_scheduler;
  import div_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned ID_W  = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_div0;
  logic                  busy;

  div_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div0(rsp_div0), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [15:0] q;
    logic [15:0] r;
    logic        div0;
    int unsigned lat;
    int unsigned acc_edge;
  } exp_t;

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dsr;
  } op_t;

  exp_t sb[$];
  exp_t cur;
  op_t  opq0[$];
  op_t  opq1[$];
  int   grant_log[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned n_acc = 0;
  bit          rand_rdy = 1'b0;

  // Reference occupancy / arbitration model
  bit          m_busy = 1'b0;
  int          m_ptr  = NREQ - 1;
  bit          in_rsp = 1'b0;
  bit          exp_retire = 1'b0;
  int unsigned last_acc_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Next requester after ptr (wrapping) that has a request pending.
  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int s = 1; s <= int'(NREQ); s++) begin
      int c;
      c = (ptr + s) % int'(NREQ);
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rnd_dsr();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(1, 15));
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Driver: presents the head of each requester queue until it is accepted.
  initial begin : driver
    logic [NREQ-1:0] hs;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b1;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready & {NREQ{~rst}};
      @(posedge clk);
      #1;
      if (hs[0] && opq0.size() > 0) void'(opq0.pop_front());
      if (hs[1] && opq1.size() > 0) void'(opq1.pop_front());
      if (opq0.size() > 0) begin
        req_valid[0] = 1'b1;
        req_dividend[15:0] = opq0[0].dvd;
        req_divisor[15:0]  = opq0[0].dsr;
      end else req_valid[0] = 1'b0;
      if (opq1.size() > 0) begin
        req_valid[1] = 1'b1;
        req_dividend[31:16] = opq1[0].dvd;
        req_divisor[31:16]  = opq1[0].dsr;
      end else req_valid[1] = 1'b0;
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: models the scheduler from its rules and scores every response.
  always @(negedge clk) begin : monitor
    bit              was_busy;
    int              p;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] hs;
    exp_t            e;
    if (rst) begin
      sb.delete();
      m_busy     = 1'b0;
      m_ptr      = NREQ - 1;
      in_rsp     = 1'b0;
      exp_retire = 1'b0;
    end else begin
      was_busy = m_busy;
      if (exp_retire) begin
        check("rsp_valid_after_retire", 32'(rsp_valid), 32'd0);
        exp_retire = 1'b0;
      end
      check("busy", 32'(busy), 32'(was_busy));
      exp_rdy = '0;
      p = was_busy ? -1 : rr_pick(m_ptr, req_valid);
      if (p >= 0) exp_rdy[p] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));

      // Response side
      if (in_rsp) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_id", 32'(rsp_id), cur.id);
        check("rsp_hold_q", 32'(rsp_quotient), 32'(cur.q));
        check("rsp_hold_r", 32'(rsp_remainder), 32'(cur.r));
        check("rsp_hold_div0", 32'(rsp_div0), 32'(cur.div0));
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          cur = sb.pop_front();
          in_rsp = 1'b1;
          check("rsp_id", 32'(rsp_id), cur.id);
          check("rsp_quotient", 32'(rsp_quotient), 32'(cur.q));
          check("rsp_remainder", 32'(rsp_remainder), 32'(cur.r));
          check("rsp_div0", 32'(rsp_div0), 32'(cur.div0));
          check("rsp_latency", cyc - cur.acc_edge + 1, cur.lat);
        end
      end
      if (in_rsp && rsp_valid && rsp_ready) begin
        exp_retire = 1'b1;
        in_rsp     = 1'b0;
        m_busy     = 1'b0;
      end

      // Request side: accept happens at the coming edge
      if (!was_busy && p >= 0) begin
        hs = req_valid & req_ready;
        grant_log.push_back(hs == 2'b01 ? 0 : (hs == 2'b10 ? 1 : -1));
        e.id       = p;
        e.acc_edge = cyc + 1;
        if (req_divisor[p*16 +: 16] == 16'h0) begin
          e.q = 16'hFFFF; e.r = req_dividend[p*16 +: 16]; e.div0 = 1'b1; e.lat = 1;
        end else begin
          e.q    = req_dividend[p*16 +: 16] / req_divisor[p*16 +: 16];
          e.r    = req_dividend[p*16 +: 16] % req_divisor[p*16 +: 16];
          e.div0 = 1'b0;
          e.lat  = WIDTH + 1;
        end
        sb.push_back(e);
        m_ptr  = p;
        m_busy = 1'b1;
        last_acc_edge = cyc + 1;
        n_acc++;
      end

      if (m_busy && !in_rsp && (cyc > last_acc_edge + 100)) begin
        check("rsp_timeout", 32'd1, 32'd0);
        m_busy = 1'b0;
        sb.delete();
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] dvd, input logic [15:0] dsr);
    op_t o;
    o.dvd = dvd;
    o.dsr = dsr;
    if (i == 0) opq0.push_back(o);
    else        opq1.push_back(o);
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n = 0;
    while ((opq0.size() > 0 || opq1.size() > 0 || m_busy || sb.size() > 0) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_q"}, 32'(rsp_quotient), 32'd0);
    check({tag, "_rsp_r"}, 32'(rsp_remainder), 32'd0);
    check({tag, "_rsp_div0"}, 32'(rsp_div0), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    int exp_order[4];
    int n;
    int acc0;
    exp_order = '{0, 1, 0, 1};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #2;

    // Normal divide and divide-by-zero
    issue(0, 16'h1234, 16'h00FF);
    wait_quiet(200, "t1");
    issue(1, 16'h1234, 16'h0000);
    wait_quiet(200, "t2");

    // Edge values; last one on requester 1 leaves requester 0 next in line
    issue(0, 16'hFFFF, 16'h0001);
    wait_quiet(200, "t3a");
    issue(1, 16'h0005, 16'h0007);
    wait_quiet(200, "t3b");
    issue(1, 16'hFFFF, 16'hFFFF);
    wait_quiet(200, "t3c");

    // Round-robin with both requesters continuously valid
    grant_log.delete();
    issue(0, 16'd100, 16'd7);
    issue(1, 16'd200, 16'd9);
    issue(0, 16'd300, 16'd11);
    issue(1, 16'd400, 16'd13);
    wait_quiet(400, "t4");
    check("rr_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));

    // Backpressure: result held for 5 cycles while the other requester waits
    rsp_ready = 1'b0;
    issue(0, 16'hBEEF, 16'h0123);
    issue(1, 16'h7777, 16'h0003);
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #2; n++; end
    check("t5_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (5) @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    wait_quiet(400, "t5");

    // Reset in the middle of an operation from requester 1
    issue(1, 16'hABCD, 16'h0011);
    acc0 = n_acc;
    n = 0;
    while (n_acc == acc0 && n < 40) begin @(posedge clk); #2; n++; end
    check("t6_accepted", 32'(n_acc != acc0), 32'd1);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    opq0.delete();
    opq1.delete();
    check_reset_outputs("t6_reset");
    repeat (30) @(posedge clk);
    #2;
    grant_log.delete();
    issue(1, 16'h0042, 16'h0005);
    issue(0, 16'h0099, 16'h0004);
    wait_quiet(400, "t6");
    check("t6_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) check("t6_first_grant", 32'(grant_log[0]), 32'd0);

    // Randomized traffic with random response backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      if (opq0.size() == 0 && $urandom_range(0, 1) == 1) issue(0, 16'($urandom), rnd_dsr());
      if (opq1.size() == 0 && $urandom_range(0, 1) == 1) issue(1, 16'($urandom), rnd_dsr());
      @(posedge clk); #2;
    end
    wait_quiet(2000, "rand");
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
